// File: rtl/pma_pll_seq_pkg.sv
// pma_pll_seq_pkg: state encodings, retry width and counter sizing for pma_pll_sequencer
package pma_pll_seq_pkg;
  typedef enum logic [2:0] {
    RESET     = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;
  localparam int RETRY_W   = 4;
  localparam int RETRY_SAT = 15;
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic 1-bit two-flop synchroniser with synchronous active-low reset
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk) begin
    if (!rst_n) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
  end
endmodule

// File: rtl/pma_pll_sequencer.sv
// pma_pll_sequencer: PMA TX PLL reset/lock sequencer with timeout retry and lock-loss restart.
// Define PMA_PLL_SEQ_FAULT_EN to enter FAULT once retry_count reaches MAX_RETRIES.
module pma_pll_sequencer
  import pma_pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 10000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7
) (
  input  logic               clk_in,
  input  logic               reset_n,
  input  logic               pll_locked,
  input  logic               restart,
  input  logic               clear_status,
  output logic               pll_reset,
  output logic               pma_reset_n,
  output logic               ready,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_count,
  output logic [2:0]         state,
  output logic               fault
);
  localparam int CW = cnt_w(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
`ifdef PMA_PLL_SEQ_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_d, retry_sat;
  logic lock_s, inc, set_lost, lost_d, fault_hit;
  sync_2ff u_sync (
    .clk  (clk_in),
    .rst_n(reset_n),
    .d    (pll_locked),
    .q    (lock_s)
  );
  assign retry_sat = (retry_count == RETRY_W'(RETRY_SAT)) ? retry_count : retry_count + 1'b1;
  assign fault_hit = FAULT_EN && (retry_sat == RETRY_W'(MAX_RETRIES));
  assign state     = state_q;
  // restart overrides every lock/timeout event, so it is evaluated ahead of the state case
  always_comb begin
    state_d  = state_q;
    inc      = 1'b0;
    set_lost = 1'b0;
    if (restart) state_d = RESET;
    else begin
      case (state_q)
        RESET:     state_d = (cnt_q == CW'(RST_CYCLES - 1)) ? WAIT_LOCK : RESET;
        WAIT_LOCK: begin
          if (lock_s) state_d = STABLE;
          else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
            inc     = 1'b1;
            state_d = fault_hit ? FAULT : RESET;
          end
        end
        STABLE:    state_d = !lock_s ? WAIT_LOCK : (cnt_q == CW'(STABLE_CYCLES - 1)) ? RUN : STABLE;
        RUN: begin
          set_lost = !lock_s;
          state_d  = lock_s ? RUN : RESET;
        end
        default:   state_d = state_q;
      endcase
    end
    cnt_d   = (restart || state_d != state_q) ? '0 : cnt_q + 1'b1;
    retry_d = inc ? retry_sat : (clear_status || (restart && state_q == FAULT)) ? '0 : retry_count;
    lost_d  = set_lost || (lock_lost && !clear_status);
  end
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state_q     <= RESET;
      cnt_q       <= '0;
      retry_count <= '0;
      lock_lost   <= 1'b0;
      pll_reset   <= 1'b1;
      pma_reset_n <= 1'b0;
      ready       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_count <= retry_d;
      lock_lost   <= lost_d;
      pll_reset   <= (state_d == RESET) || (state_d == FAULT);
      pma_reset_n <= state_d == RUN;
      ready       <= state_d == RUN;
    end
  end
`ifdef PMA_PLL_SEQ_FAULT_EN
  always_ff @(posedge clk_in) begin
    if (!reset_n) fault <= 1'b0;
    else fault <= state_d == FAULT;
  end
`else
  assign fault = 1'b0;
`endif
endmodule

// File: tb/tb_pma_pll_sequencer.sv
// tb_pma_pll_sequencer: directed scenarios plus random traffic, checked every cycle against a phase/age model
module tb_pma_pll_sequencer;
  localparam int RST_N = 16;
  localparam int TO    = 1000;
  localparam int STB   = 1024;
  localparam int MAXR  = 7;
  logic clk_in = 1'b0, reset_n = 1'b0, pll_locked = 1'b0, restart = 1'b0, clear_status = 1'b0;
  logic pll_reset, pma_reset_n, ready, lock_lost, fault;
  logic [3:0] retry_count;
  logic [2:0] state;
  int total = 0, bad = 0;
  bit armed = 1'b0;
  int m_phase = 0, m_age = 0, m_retries = 0;
  bit m_lost = 1'b0, m_h1 = 1'b0, m_h2 = 1'b0;

  always #5 clk_in = ~clk_in;

  pma_pll_sequencer #(
    .RST_CYCLES   (RST_N),
    .LOCK_TIMEOUT (TO),
    .STABLE_CYCLES(STB),
    .MAX_RETRIES  (MAXR)
  ) dut (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .restart     (restart),
    .clear_status(clear_status),
    .pll_reset   (pll_reset),
    .pma_reset_n (pma_reset_n),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .retry_count (retry_count),
    .state       (state),
    .fault       (fault)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // phase = spec state number, age = cycles already spent in the phase,
  // lock seen by the sequencer = pll_locked as sampled two edges earlier
  task automatic model_step(input bit rn, input bit pl, input bit rs, input bit cs);
    bit lk, inc, setl;
    int nxt;
    if (!rn) begin
      m_phase = 0; m_age = 0; m_retries = 0; m_lost = 0; m_h1 = 0; m_h2 = 0; armed = 1;
      return;
    end
    lk = m_h2; m_h2 = m_h1; m_h1 = pl;
    inc = 0; setl = 0; nxt = m_phase;
    if (rs) nxt = 0;
    else if (m_phase == 0) begin
      if (m_age + 1 >= RST_N) nxt = 1;
    end else if (m_phase == 1) begin
      if (lk) nxt = 2;
      else if (m_age + 1 >= TO) begin inc = 1; nxt = 0; end
    end else if (m_phase == 2) begin
      if (!lk) nxt = 1;
      else if (m_age + 1 >= STB) nxt = 3;
    end else if (m_phase == 3) begin
      if (!lk) begin setl = 1; nxt = 0; end
    end
    if (inc) begin
      m_retries = (m_retries < 15) ? m_retries + 1 : 15;
`ifdef PMA_PLL_SEQ_FAULT_EN
      if (m_retries == MAXR) nxt = 4;
`endif
    end else if (cs || (rs && m_phase == 4)) m_retries = 0;
    m_lost  = setl || (m_lost && !cs);
    m_age   = (rs || nxt != m_phase) ? 0 : m_age + 1;
    m_phase = nxt;
  endtask

  initial begin
    forever begin
      @(posedge clk_in);
      model_step(reset_n, pll_locked, restart, clear_status);
      #1;
      if (armed) begin
        chk("state", int'(state), m_phase);
        chk("pll_reset", int'(pll_reset), int'(m_phase == 0 || m_phase == 4));
        chk("pma_reset_n", int'(pma_reset_n), int'(m_phase == 3));
        chk("ready", int'(ready), int'(m_phase == 3));
        chk("fault", int'(fault), int'(m_phase == 4));
        chk("lock_lost", int'(lock_lost), int'(m_lost));
        chk("retry_count", int'(retry_count), m_retries);
      end
    end
  end

  initial begin
    int n, run, pulses;
    repeat (5) @(negedge clk_in);
    chk("rst_state", int'(state), 0);
    chk("rst_pll_reset", int'(pll_reset), 1);
    chk("rst_pma_reset_n", int'(pma_reset_n), 0);
    chk("rst_ready", int'(ready), 0);
    chk("rst_retry", int'(retry_count), 0);
    // normal bring-up
    reset_n = 1; n = 0;
    while (pll_reset && n < 100) begin n++; @(negedge clk_in); end
    chk("bringup_pulse_len", n, 16);
    repeat (50) @(negedge clk_in);
    pll_locked = 1; n = 0;
    do begin @(negedge clk_in); n++; end while (!ready && n < 5000);
    chk("bringup_latency", n, 1027);
    chk("bringup_retry", int'(retry_count), 0);
    // timeout retries
    reset_n = 0; pll_locked = 0;
    repeat (3) @(negedge clk_in);
    reset_n = 1; run = 0; pulses = 0;
    for (int i = 0; i < 2500; i++) begin
      if (pll_reset) run++;
      else if (run > 0) begin pulses++; chk("retry_pulse_len", run, 16); run = 0; end
      @(negedge clk_in);
    end
    chk("retry_pulses", pulses, 3);
    pll_locked = 1; n = 0;
    do begin @(negedge clk_in); n++; end while (!ready && n < 3000);
    chk("retry_reach_run", int'(ready), 1);
    chk("retry_count_2", int'(retry_count), 2);
    // glitch during STABLE
    restart = 1; @(negedge clk_in); restart = 0; n = 0;
    while (state != 3'd2 && n < 200) begin n++; @(negedge clk_in); end
    repeat (500) @(negedge clk_in);
    pll_locked = 0; repeat (4) @(negedge clk_in); pll_locked = 1; n = 0;
    do begin @(negedge clk_in); n++; end while (!ready && n < 5000);
    chk("glitch_latency", n, 1027);
    chk("glitch_retry", int'(retry_count), 2);
    // lock loss in RUN
    pll_locked = 0; n = 0;
    do begin @(negedge clk_in); n++; end while (pma_reset_n && n < 20);
    chk("loss_latency", n, 3);
    chk("loss_flag", int'(lock_lost), 1);
    chk("loss_ready", int'(ready), 0);
    n = 0;
    while (pll_reset && n < 100) begin n++; @(negedge clk_in); end
    chk("loss_pulse_len", n, 16);
    clear_status = 1; @(negedge clk_in); clear_status = 0;
    chk("clear_lost", int'(lock_lost), 0);
    chk("clear_retry", int'(retry_count), 0);
    // persistent lock failure
`ifdef PMA_PLL_SEQ_FAULT_EN
    n = 0;
    while (!fault && n < 20000) begin @(negedge clk_in); n++; end
    chk("fault_flag", int'(fault), 1);
    chk("fault_retry", int'(retry_count), 7);
    chk("fault_pll_reset", int'(pll_reset), 1);
    chk("fault_state", int'(state), 4);
    repeat (50) @(negedge clk_in);
    chk("fault_hold", int'(state), 4);
    restart = 1; @(negedge clk_in); restart = 0;
    chk("fault_restart_state", int'(state), 0);
    chk("fault_restart_retry", int'(retry_count), 0);
    chk("fault_restart_flag", int'(fault), 0);
`else
    repeat (17 * (TO + RST_N)) @(negedge clk_in);
    chk("sat_retry", int'(retry_count), 15);
    chk("sat_fault", int'(fault), 0);
`endif
    // restart on the timeout cycle
    reset_n = 0; pll_locked = 0; @(negedge clk_in); reset_n = 1; n = 0;
    while (pll_reset && n < 100) begin n++; @(negedge clk_in); end
    repeat (TO - 1) @(negedge clk_in);
    restart = 1; @(negedge clk_in); restart = 0;
    chk("sim_restart_state", int'(state), 0);
    chk("sim_restart_retry", int'(retry_count), 0);
    // clear_status on the lock-drop cycle
    pll_locked = 1; n = 0;
    do begin @(negedge clk_in); n++; end while (!ready && n < 3000);
    chk("sim_reach_run", int'(ready), 1);
    pll_locked = 0; repeat (2) @(negedge clk_in);
    clear_status = 1; @(negedge clk_in); clear_status = 0;
    chk("sim_clear_lost", int'(lock_lost), 1);
    chk("sim_clear_state", int'(state), 0);
    // random traffic
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 1499) == 0) pll_locked = ~pll_locked;
      else if ($urandom_range(0, 999) == 0) pll_locked = 0;
      restart      = ($urandom_range(0, 599) == 0);
      clear_status = ($urandom_range(0, 199) == 0);
      reset_n      = ($urandom_range(0, 2999) != 0);
      @(negedge clk_in);
    end
    restart = 0; clear_status = 0; reset_n = 1;
    repeat (5) @(negedge clk_in);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pma_pll_sequencer.md
# pma_pll_sequencer

Reset and lock sequencer for the PMA transmit PLL on the SFP PHY. Runs on the free-running 100 MHz board clock. Drives the PLL reset pulse, waits for lock with a timeout and retry, and qualifies lock stability before releasing the 125 MHz PMA domain reset. Monitors for lock loss during operation and restarts the PLL automatically.

## Interface
- `RST_CYCLES`, 16: cycles `pll_reset` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, 10000: cycles allowed in WAIT_LOCK before a retry (100 µs at 100 MHz).
- `STABLE_CYCLES`, 1024: consecutive synchronised-lock cycles required before release.
- `MAX_RETRIES`, 7: timeout count that triggers FAULT (used only with `PMA_PLL_SEQ_FAULT_EN`; 1..15).

Ports:
- `clk_in`, in, 1: 100 MHz reference clock, also the PLL input clock.
- `reset_n`, in, 1: reset, synchronous, active-low.
- `pll_locked`, in, 1: PLL `locked`, asynchronous to `clk_in`.
- `restart`, in, 1: single-cycle request to re-run the sequence.
- `clear_status`, in, 1: single-cycle clear of `lock_lost` and `retry_count`.
- `pll_reset`, out, 1: to PLL `reset`, active-high.
- `pma_reset_n`, out, 1: active-low reset for PMA logic. Consumers re-synchronise it into the 125 MHz domain.
- `ready`, out, 1: high only in RUN.
- `lock_lost`, out, 1: sticky flag, set when lock drops in RUN.
- `retry_count`, out, 4: lock-timeout count, saturates at 15.
- `state`, out, 3: current FSM state, for debug.
- `fault`, out, 1: high in FAULT.

## Operation
- `pll_locked` passes through a 2-flop synchroniser to give `lock_s`. Both flops reset to 0.
- States and encodings: RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.
- **RESET**
  - `pll_reset`=1 for exactly `RST_CYCLES` cycles, then go to WAIT_LOCK.
  - The counter clears on every entry.
- **WAIT_LOCK**
  - `pll_reset`=0 and the timer counts up.
  - If `lock_s`=1, go to STABLE.
  - If the timer reaches `LOCK_TIMEOUT`-1 without lock, increment `retry_count` and go to RESET.
- **STABLE**
  - The counter counts cycles with `lock_s`=1.
  - If `lock_s`=0, go to WAIT_LOCK. The timer restarts and there is no retry increment.
  - After `STABLE_CYCLES` consecutive cycles, go to RUN.
- **RUN**
  - `pma_reset_n`=1 and `ready`=1.
  - If `lock_s`=0, set `lock_lost` and go to RESET.
- **FAULT**
  - `pll_reset` is held at 1 and `fault`=1.
  - Exit only on `restart` or `reset_n`.
- **restart**
  - From any state, go to RESET on the next cycle.
  - From FAULT, `restart` also clears `retry_count`.
  - `restart` has priority over every lock or timeout event in the same cycle.
- **clear_status**
  - Clears `lock_lost` and `retry_count`.
  - If a set or increment event occurs in the same cycle, the set/increment wins.
- **Widths**
  - Use one shared counter, width `$clog2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES))`.
  - `retry_count` increments saturate at 15.

## Timing
- **Values in reset** (while `reset_n`=0, applied at the clock edge):
  - state RESET, counter 0
  - `pll_reset`=1, `pma_reset_n`=0, `ready`=0, `fault`=0
  - `lock_lost`=0, `retry_count`=0
- **Registering:** all outputs are registered and change in the same cycle as the state they reflect.
- **Lock-loss latency:** a falling edge on `pll_locked` pin drives `pma_reset_n` and `ready` low 3 `clk_in` edges later (2 synchroniser + 1 FSM).
- **Lock-acquire latency:** `pll_locked` rising to `ready` takes 2 + 1 + `STABLE_CYCLES` cycles.
- **Minimum `pll_reset` pulse:** `RST_CYCLES` cycles. The pulse is never shortened, except by `reset_n`.
- **Reset mid-operation:** `reset_n` low in any state aborts immediately to RESET with all reset values.

## Configuration
- **Macro:** `PMA_PLL_SEQ_FAULT_EN`.
- **Defined:** when a timeout makes `retry_count` equal `MAX_RETRIES`, go to FAULT instead of RESET.
- **Undefined:**
  - Retries continue indefinitely and FAULT is unreachable.
  - `fault` is tied to 0.
  - `MAX_RETRIES` is ignored.

## Structure
- **Package `pma_pll_seq_pkg`:**
  - state enum and encodings
  - `RETRY_W`=4 and `RETRY_SAT`=15
  - counter-width helper function
- **Sub-module `sync_2ff`:** a generic 1-bit, 2-flop synchroniser with synchronous active-low reset. Instance it once for `pll_locked`.

## Test plan
- **Normal bring-up:** release `reset_n` and assert `pll_locked` 50 cycles after `pll_reset` falls.
  - `pll_reset` is high for exactly 16 cycles.
  - `ready` rises 1027 cycles after the `pll_locked` edge.
  - `retry_count`=0.
- **Timeout retry:** hold `pll_locked`=0 for 25000 cycles, then assert it.
  - Two retries occur and `retry_count`=2.
  - Each RESET pulse is 16 cycles.
  - The PLL then reaches RUN.
- **Glitch during STABLE:** drop `pll_locked` for 4 cycles at stable count 500.
  - Return to WAIT_LOCK with no retry increment.
  - `ready` comes only after a full 1024-cycle window.
- **Lock loss in RUN:** deassert `pll_locked`.
  - `pma_reset_n` is 0 three edges later and `lock_lost`=1.
  - `pll_reset` pulses for 16 cycles.
  - `clear_status` then clears `lock_lost` to 0.
- **Fault, with macro defined:** hold lock low.
  - On the 7th timeout, go to FAULT with `fault`=1 and `pll_reset`=1.
  - `restart` returns to RESET with `retry_count`=0.
  - Without the macro, `retry_count` saturates at 15 and `fault` stays 0.
- **Simultaneous events:** `restart` in the same cycle as a timeout, and `clear_status` in the same cycle as a lock drop in RUN.
  - Go to RESET with no increment.
  - `lock_lost`=1.
